// File: rtl/tb4004_bus_pkg.sv
// Shared definitions for 4001/4002-style responders on the CPU's 4-bit
// instruction-cycle bus: microcycle numbers, I/O opcodes, phase helpers.
package tb4004_bus_pkg;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    localparam logic [7:0] OP_WRR = 8'hE2;
    localparam logic [7:0] OP_RDR = 8'hEA;

    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_READ  = 2'd1,
        PH_EXEC  = 2'd2
    } phase_t;

    typedef enum logic {
        TRK_FREE   = 1'b0,
        TRK_LOCKED = 1'b1
    } trk_state_t;

    typedef struct packed {
        logic [3:0] adr_lo;
        logic       sel;
        logic [7:0] op;
        logic [3:0] opa_hold;
    } fetch_t;

    // Address out in A1..A3, memory data in M1/M2, execution in X1..X3.
    function automatic phase_t phase_of(input logic [2:0] cyc);
        if (cyc <= CYC_A3) begin
            return PH_FETCH;
        end
        if (cyc <= CYC_M2) begin
            return PH_READ;
        end
        return PH_EXEC;
    endfunction

    function automatic logic chip_match(
        input logic [3:0] nib,
        input logic [3:0] id
    );
        return nib == id;
    endfunction

endpackage

// File: rtl/bus_cycle_tracker.sv
// Follows the CPU's T0..T7 microcycle from SYNC; shared by ROM- and
// RAM-side responders so every chip on the bus agrees on the phase.
module bus_cycle_tracker
    import tb4004_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    output logic       locked,
    output logic [2:0] cyc,
    output logic       sync_err
);

    trk_state_t state_q;
    trk_state_t state_d;
    logic [2:0] cyc_q;
    logic [2:0] cyc_d;
    logic       err_q;
    logic       err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRK_FREE;
            cyc_q   <= CYC_A1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    // SYNC always wins: it marks X3, so the next clock is A1.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        err_d   = 1'b0;
        if (sync) begin
            state_d = TRK_LOCKED;
            cyc_d   = CYC_A1;
            err_d   = (state_q == TRK_LOCKED) && (cyc_q != CYC_X3);
        end else if (state_q == TRK_LOCKED) begin
            cyc_d = cyc_q + 3'd1;
        end else begin
            cyc_d = CYC_A1;
        end
    end

    assign locked   = (state_q == TRK_LOCKED);
    assign cyc      = cyc_q;
    assign sync_err = err_q;

endmodule

// File: rtl/rom_bus_responder.sv
// ROM-side bus responder: collects the fetch address, returns the opcode
// in M1/M2 when selected, and owns one SRC-selected 4-bit I/O port.
module rom_bus_responder
    import tb4004_bus_pkg::*;
#(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       cm_rom,
    input  logic [3:0] d_in,
    output logic [3:0] d_out,
    output logic       d_oe,
    output logic       rom_rd,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] io_in,
    output logic [3:0] io_out,
    output logic       locked,
    output logic       sync_err
);

    logic [2:0] cyc;
    fetch_t     f;
    logic       io_sel;
    logic       in_read;
    logic       m1_go;
    logic       m2_go;
    logic       rdr_go;

    bus_cycle_tracker u_trk (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .locked   (locked),
        .cyc      (cyc),
        .sync_err (sync_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f        <= '0;
            io_sel   <= 1'b0;
            io_out   <= 4'h0;
            rom_rd   <= 1'b0;
            rom_addr <= 8'h00;
        end else begin
            rom_rd <= 1'b0;
            if (locked) begin
                unique case (cyc)
                    CYC_A1: f.adr_lo <= d_in;
                    CYC_A2: begin
                        rom_addr <= {d_in, f.adr_lo};
                        rom_rd   <= 1'b1;
                    end
                    CYC_A3: f.sel <= chip_match(d_in, CHIP_ID);
                    // Opcode comes off the bus so unselected chips still decode it.
                    CYC_M1: begin
                        f.op[7:4]  <= d_in;
                        f.opa_hold <= rom_data[3:0];
                    end
                    CYC_M2: f.op[3:0] <= d_in;
                    CYC_X1: ;
                    CYC_X2: begin
                        if (cm_rom) begin
                            io_sel <= chip_match(d_in, CHIP_ID);
                        end else if (io_sel && f.op == OP_WRR) begin
                            io_out <= d_in;
                        end
                    end
                    CYC_X3: ;
                    default: ;
                endcase
            end
        end
    end

    assign in_read = locked && (phase_of(cyc) == PH_READ) && f.sel;
    assign m1_go   = in_read && (cyc == CYC_M1);
    assign m2_go   = in_read && (cyc == CYC_M2);
    assign rdr_go  = locked && (cyc == CYC_X2) && !cm_rom
                   && io_sel && (f.op == OP_RDR);

    // Drive depends only on registered state plus rom_data/io_in, never d_in.
    always_comb begin
        d_oe  = 1'b0;
        d_out = 4'h0;
        unique case (1'b1)
            m1_go: begin
                d_oe  = 1'b1;
                d_out = rom_data[7:4];
            end
            m2_go: begin
                d_oe  = 1'b1;
                d_out = f.opa_hold;
            end
            rdr_go: begin
                d_oe  = 1'b1;
                d_out = io_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rom_bus_responder.sv
// Directed bench for rom_bus_responder with an instruction-level bus model.
module tb_rom_bus_responder;

    localparam logic [3:0] CHIP = 4'h2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       cm_rom;
    logic [3:0] cpu_drv;
    logic [3:0] d_in;
    logic [3:0] d_out;
    logic       d_oe;
    logic       rom_rd;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic       locked;
    logic       sync_err;

    logic [7:0] rom [256];

    always #5 clk = ~clk;

    assign d_in = d_oe ? d_out : cpu_drv;

    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom[rom_addr];
    end

    rom_bus_responder #(.CHIP_ID(CHIP)) dut (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .cm_rom   (cm_rom),
        .d_in     (d_in),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .io_in    (io_in),
        .io_out   (io_out),
        .locked   (locked),
        .sync_err (sync_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expectations for the cycle in progress
    bit         exp_valid;
    logic       exp_oe, exp_locked, exp_serr, exp_rd;
    logic [3:0] exp_out, exp_io;
    logic [7:0] exp_raddr;
    int         cur_ph;

    logic       obs_oe   [8];
    logic       obs_serr [8];
    logic [3:0] obs_out  [8];

    // Model state
    logic       m_locked, m_serr_next, m_iosel;
    logic [3:0] m_io;
    logic [7:0] m_raddr;

    always @(negedge clk) begin
        if (exp_valid && !rst) begin
            chk("d_oe", d_oe, exp_oe);
            chk("d_out", d_out, exp_out);
            chk("locked", locked, exp_locked);
            chk("sync_err", sync_err, exp_serr);
            chk("rom_rd", rom_rd, exp_rd);
            chk("io_out", io_out, exp_io);
            if (exp_rd) chk("rom_addr", rom_addr, exp_raddr);
            if (cur_ph >= 0 && cur_ph < 8) begin
                obs_oe[cur_ph]   = d_oe;
                obs_out[cur_ph]  = d_out;
                obs_serr[cur_ph] = sync_err;
            end
        end
    end

    task automatic step(input logic s, input logic cm, input logic [3:0] drv,
                        input logic eoe, input logic [3:0] eout, input int ph);
        @(posedge clk);
        #1;
        sync       = s;
        cm_rom     = cm;
        cpu_drv    = drv;
        exp_oe     = eoe;
        exp_out    = eout;
        exp_locked = m_locked;
        exp_serr   = m_serr_next;
        exp_rd     = m_locked && (ph == 2);
        exp_raddr  = m_raddr;
        exp_io     = m_io;
        cur_ph     = ph;
        exp_valid  = 1'b1;
        m_serr_next = s && m_locked && (ph != 7);
        if (s) m_locked = 1'b1;
    endtask

    // One CPU instruction cycle; stop_ph ends it early (with sync if ab_sync).
    task automatic run_instr(input logic [11:0] a, input logic [7:0] bop,
                             input logic src, input logic [3:0] d6,
                             input logic [3:0] iov, input logic nosync,
                             input int stop_ph, input logic ab_sync);
        logic       selm, s, cm, eoe;
        logic [7:0] b, op;
        logic [3:0] drv, eout;
        selm    = (a[11:8] == CHIP);
        b       = rom[a[7:0]];
        op      = selm ? b : bop;
        m_raddr = a[7:0];
        io_in   = iov;
        for (int i = 0; i < 8; i++) begin
            obs_oe[i]   = 1'b0;
            obs_out[i]  = 4'h0;
            obs_serr[i] = 1'b0;
        end
        for (int ph = 0; ph < 8; ph++) begin
            s = 1'b0; cm = 1'b0; drv = 4'h0; eoe = 1'b0; eout = 4'h0;
            case (ph)
                0: drv = a[3:0];
                1: drv = a[7:4];
                2: drv = a[11:8];
                3: begin
                    drv = bop[7:4];
                    if (selm) begin eoe = 1'b1; eout = b[7:4]; end
                end
                4: begin
                    drv = bop[3:0];
                    if (selm) begin eoe = 1'b1; eout = b[3:0]; end
                end
                6: begin
                    drv = d6;
                    cm  = src;
                    if (!src && op == 8'hEA && m_iosel) begin
                        eoe = 1'b1; eout = iov;
                    end
                end
                7: s = !nosync;
                default: ;
            endcase
            if (ph == stop_ph && ab_sync) s = 1'b1;
            step(s, cm, drv, eoe, eout, ph);
            if (ph == 6) begin
                if (src) m_iosel = (d6 == CHIP);
                else if (op == 8'hE2 && m_iosel) m_io = d6;
            end
            if (ph == stop_ph) break;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; cpu_drv = 4'h0; io_in = 4'h0;
        exp_valid = 1'b0; cur_ph = -1;
        m_locked = 1'b0; m_serr_next = 1'b0; m_iosel = 1'b0; m_io = 4'h0;
        m_raddr = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 1);
        rom[8'hA5] = 8'h3C;
        rom[8'h10] = 8'hEA;
        rom[8'h11] = 8'hE2;

        #12;
        chk("rst_d_oe", d_oe, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_rom_rd", rom_rd, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_io_out", io_out, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sync_err", sync_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Unlocked: no drive, no strobe, whatever is on the bus
        step(0, 1, 4'h2, 0, 4'h0, -1);
        step(0, 0, 4'hA, 0, 4'h0, -1);
        step(0, 0, 4'h2, 0, 4'h0, -1);
        step(1, 0, 4'h0, 0, 4'h0, -1);

        run_instr(12'h2A5, 8'h00, 0, 4'h0, 4'h0, 0, 8, 0);
        chk("sel_m1_oe", obs_oe[3], 1);
        chk("sel_m1_hi", obs_out[3], 4'h3);
        chk("sel_m2_lo", obs_out[4], 4'hC);

        run_instr(12'h5A5, 8'h71, 0, 4'h0, 4'h0, 0, 8, 0);
        chk("foreign_oe", obs_oe[0] | obs_oe[1] | obs_oe[2] | obs_oe[3]
                        | obs_oe[4] | obs_oe[5] | obs_oe[6] | obs_oe[7], 0);

        run_instr(12'h123, 8'h00, 1, 4'h2, 4'h0, 0, 8, 0);
        run_instr(12'h124, 8'hE2, 0, 4'h9, 4'h0, 0, 8, 0);
        chk("wrr_io_out", io_out, 4'h9);
        run_instr(12'h125, 8'hEA, 0, 4'h0, 4'h6, 0, 8, 0);
        chk("rdr_out", obs_out[6], 4'h6);
        chk("rdr_oe", obs_oe[6], 1);
        chk("rdr_oe_x3", obs_oe[7], 0);

        // SRC beats WRR in the same X2, then io_sel stays cleared
        run_instr(12'h126, 8'hE2, 1, 4'h5, 4'h0, 0, 8, 0);
        chk("src_prio_io", io_out, 4'h9);
        run_instr(12'h127, 8'hE2, 0, 4'h3, 4'h0, 0, 8, 0);
        chk("unsel_wrr_io", io_out, 4'h9);

        // Selected chip fetches its own RDR / WRR opcodes
        run_instr(12'h300, 8'h00, 1, 4'h2, 4'h0, 0, 8, 0);
        run_instr(12'h210, 8'h00, 0, 4'h0, 4'hB, 0, 8, 0);
        chk("own_rdr_out", obs_out[6], 4'hB);
        run_instr(12'h211, 8'h00, 0, 4'h4, 4'h0, 0, 8, 0);
        chk("own_wrr_io", io_out, 4'h4);

        // Missing sync: silent wrap
        run_instr(12'h2A5, 8'h00, 0, 4'h0, 4'h0, 1, 8, 0);
        run_instr(12'h2A5, 8'h00, 0, 4'h0, 4'h0, 0, 8, 0);
        chk("nosync_err", obs_serr[0], 0);
        chk("nosync_hi", obs_out[3], 4'h3);

        // Early sync at cyc 4
        run_instr(12'h2A5, 8'h00, 0, 4'h0, 4'h0, 0, 4, 1);
        run_instr(12'h2A5, 8'h00, 0, 4'h0, 4'h0, 0, 8, 0);
        chk("early_sync_err", obs_serr[0], 1);
        chk("early_sync_err1", obs_serr[1], 0);
        chk("realign_hi", obs_out[3], 4'h3);
        chk("realign_lo", obs_out[4], 4'hC);

        // Reset mid-M1 while driving
        run_instr(12'h2A5, 8'h00, 0, 4'h0, 4'h0, 0, 3, 0);
        chk("pre_rst_oe", d_oe, 1);
        rst = 1'b1;
        exp_valid = 1'b0;
        #1;
        chk("async_rst_oe", d_oe, 0);
        chk("async_rst_out", d_out, 0);
        chk("async_rst_io", io_out, 0);
        chk("async_rst_lock", locked, 0);
        m_locked = 1'b0; m_serr_next = 1'b0; m_iosel = 1'b0; m_io = 4'h0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        step(0, 0, 4'h0, 0, 4'h0, -1);
        step(1, 0, 4'h0, 0, 4'h0, -1);
        run_instr(12'h2A5, 8'h00, 0, 4'h0, 4'h0, 0, 8, 0);
        chk("post_rst_hi", obs_out[3], 4'h3);
        chk("post_rst_lo", obs_out[4], 4'hC);

        exp_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
